icache: RTL and testbench

ICACHE -- requirements
Module: icache

---
 rtl/icache_pkg.sv | 15 +
 rtl/icache_array.sv | 56 +++++
 rtl/icache.sv | 139 +++++++++++++
 tb/tb_icache.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared constants and FSM encoding for the direct-mapped instruction cache.
// Index width default and line geometry live here so the top and the array agree.
package icache_pkg;

    localparam int IDX_W_DEF      = 6;
    localparam int LINE_WORDS_DEF = 4;
    localparam int WORD_W         = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/icache_array.sv
// Tag/valid/data storage: one combinational read port, one word-write port,
// and a line-claim port that writes the tag and clears valid in one step.
module icache_array
    import icache_pkg::*;
#(
    parameter int IDX_W      = IDX_W_DEF,
    parameter int TAG_W      = 22,
    parameter int LINE_WORDS = LINE_WORDS_DEF,
    parameter int OFF_W      = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [IDX_W-1:0]                   rd_idx,
    output logic                               rd_valid,
    output logic [TAG_W-1:0]                   rd_tag,
    output logic [LINE_WORDS-1:0][WORD_W-1:0]  rd_line,
    input  logic [IDX_W-1:0]                   wr_idx,
    input  logic                               line_we,
    input  logic [TAG_W-1:0]                   line_tag,
    input  logic                               val_set,
    input  logic                               word_we,
    input  logic [OFF_W-1:0]                   word_sel,
    input  logic [WORD_W-1:0]                  word_data
);

    localparam int LINES = 2 ** IDX_W;

    logic [LINES-1:0]                  valid_q;
    logic [TAG_W-1:0]                  tag_q  [LINES];
    logic [LINE_WORDS-1:0][WORD_W-1:0] data_q [LINES];

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_line  = data_q[rd_idx];

    // Claiming a line invalidates it until its final word lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (line_we) begin
            valid_q[wr_idx] <= 1'b0;
        end else if (val_set) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (line_we) begin
            tag_q[wr_idx] <= line_tag;
        end
        if (word_we) begin
            data_q[wr_idx][word_sel] <= word_data;
        end
    end

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache: one outstanding fetch, hits answer next cycle,
// misses fill a whole line word by word from the memory controller.
module icache
    import icache_pkg::*;
#(
    parameter int IDX_W      = IDX_W_DEF,
    parameter int LINE_WORDS = LINE_WORDS_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        IF_pc_sgn,
    input  logic [31:0] IF_pc,
    output logic        IF_ins_sgn,
    output logic [31:0] IF_ins,
    input  logic        flush,
    output logic        MC_req,
    output logic [31:0] MC_addr,
    input  logic        MC_done,
    input  logic [31:0] MC_data,
    output logic [1:0]  dbg_state
);

    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int TAG_W = 32 - IDX_W - OFF_W - 2;

    // MC handshake: MC_req is level and stays up with MC_addr stable until the
    // controller answers with a one-cycle MC_done carrying MC_data.
    state_t             state, state_nx;
    logic [31:2]        pc_q;
    logic [OFF_W-1:0]   cnt_q;
    logic               ins_sgn_q;
    logic [31:0]        ins_q;

    logic [IDX_W-1:0]                  rd_idx;
    logic                              rd_valid;
    logic [TAG_W-1:0]                  rd_tag;
    logic [LINE_WORDS-1:0][WORD_W-1:0] rd_line;
    logic                              hit, accept, last_word;
    logic                              line_we, word_we, val_set;
    logic                              pc_lsb_unused;

    assign pc_lsb_unused = ^IF_pc[1:0];

    // The read port follows the live request in IDLE and the latched line otherwise.
    assign rd_idx    = (state == ST_IDLE) ? IF_pc[OFF_W+2+IDX_W-1:OFF_W+2]
                                          : pc_q[OFF_W+2+IDX_W-1:OFF_W+2];
    assign hit       = rd_valid && (rd_tag == IF_pc[31:32-TAG_W]);
    assign accept    = rdy && !rst && !flush && (state == ST_IDLE) && IF_pc_sgn && !ins_sgn_q;
    assign last_word = (cnt_q == OFF_W'(LINE_WORDS - 1));

    icache_array #(
        .IDX_W      (IDX_W),
        .TAG_W      (TAG_W),
        .LINE_WORDS (LINE_WORDS),
        .OFF_W      (OFF_W)
    ) u_array (
        .clk       (clk),
        .rst       (rst),
        .rd_idx    (rd_idx),
        .rd_valid  (rd_valid),
        .rd_tag    (rd_tag),
        .rd_line   (rd_line),
        .wr_idx    (rd_idx),
        .line_we   (line_we),
        .line_tag  (IF_pc[31:32-TAG_W]),
        .val_set   (val_set),
        .word_we   (word_we),
        .word_sel  (cnt_q),
        .word_data (MC_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else if (rdy) begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (flush) begin
            state_nx = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (accept && !hit)        state_nx = ST_FILL;
                ST_FILL: if (MC_done && last_word)  state_nx = ST_RESP;
                ST_RESP:                            state_nx = ST_IDLE;
                default:                            state_nx = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        MC_req     = (state == ST_FILL);
        dbg_state  = state;
        IF_ins_sgn = ins_sgn_q && rdy;
        line_we    = accept && !hit;
        word_we    = rdy && !rst && !flush && (state == ST_FILL) && MC_done;
        val_set    = word_we && last_word;
    end

    assign IF_ins  = ins_q;
    assign MC_addr = {pc_q[31:OFF_W+2], cnt_q, 2'b00};

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= '0;
            cnt_q     <= '0;
            ins_sgn_q <= 1'b0;
            ins_q     <= '0;
        end else if (rdy) begin
            ins_sgn_q <= 1'b0;
            if (flush) begin
                cnt_q <= '0;
            end else begin
                if (accept) begin
                    pc_q  <= IF_pc[31:2];
                    cnt_q <= '0;
                    if (hit) begin
                        ins_sgn_q <= 1'b1;
                        ins_q     <= rd_line[IF_pc[OFF_W+1:2]];
                    end
                end
                if (word_we) begin
                    cnt_q <= cnt_q + OFF_W'(1);
                    // The requested word may be the one arriving this very cycle.
                    if (last_word) begin
                        ins_sgn_q <= 1'b1;
                        ins_q     <= (pc_q[OFF_W+1:2] == cnt_q) ? MC_data
                                                                : rd_line[pc_q[OFF_W+1:2]];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_icache.sv
// Bench for icache: directed table of fetches, hand-built flush/rdy/reset sequences,
// and randomized fetches checked against a tag-only cache model over a synthetic memory.
module tb_icache;
  import icache_pkg::*;

  logic        clk, rst, rdy, IF_pc_sgn, flush, MC_done;
  logic [31:0] IF_pc, MC_data;
  logic        IF_ins_sgn, MC_req;
  logic [31:0] IF_ins, MC_addr;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  bit          m_valid [64];
  logic [21:0] m_tag   [64];

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
    bit          hit;
  } vec_t;
  vec_t tbl [8];

  icache dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .IF_pc_sgn(IF_pc_sgn), .IF_pc(IF_pc),
    .IF_ins_sgn(IF_ins_sgn), .IF_ins(IF_ins),
    .flush(flush),
    .MC_req(MC_req), .MC_addr(MC_addr), .MC_done(MC_done), .MC_data(MC_data),
    .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0000_0013;
      32'h0000_0004: return 32'h0010_0093;
      32'h0000_0008: return 32'h0020_0113;
      32'h0000_000C: return 32'h0030_0193;
      default:       return (a * 32'h0001_0003) ^ 32'h1357_9BDF;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
  endtask

  // One memory beat at latency 1: called at a negedge, returns at the next negedge.
  task automatic beat(input logic [31:0] exp_addr);
    check("beat_req", {31'b0, MC_req}, 32'd1);
    check("beat_addr", MC_addr, exp_addr);
    MC_done = 1'b1;
    MC_data = mem_rd(exp_addr);
    @(negedge clk);
    MC_done = 1'b0;
    MC_data = $urandom;
  endtask

  task automatic start_req(input logic [31:0] pc);
    IF_pc     = pc;
    IF_pc_sgn = 1'b1;
    @(negedge clk);
    IF_pc_sgn = 1'b0;
    IF_pc     = $urandom;
  endtask

  // Full fetch with a serving memory of the given latency; expectations come from the model.
  task automatic do_fetch(input logic [31:0] pc, input int lat,
                          output logic got_hit, output logic [31:0] got_ins);
    int          idx, cyc, nreq;
    bit          seen, exp_hit;
    logic [21:0] tg;
    logic [1:0]  w;
    logic [31:0] exp_ins;
    idx     = int'(pc[9:4]);
    tg      = pc[31:10];
    exp_hit = m_valid[idx] && (m_tag[idx] == tg);
    exp_ins = mem_rd({pc[31:2], 2'b00});
    start_req(pc);
    cyc  = 1;
    nreq = 0;
    seen = 1'b0;
    while (!seen && cyc < 100) begin
      if (IF_ins_sgn) begin
        seen = 1'b1;
      end else if (MC_req) begin
        w = nreq[1:0];
        check("fill_addr", MC_addr, {pc[31:4], w, 2'b00});
        for (int k = 1; k < lat; k++) begin
          @(negedge clk);
          cyc++;
          check("fill_hold", MC_addr, {pc[31:4], w, 2'b00});
        end
        MC_done = 1'b1;
        MC_data = mem_rd(MC_addr);
        @(negedge clk);
        MC_done = 1'b0;
        MC_data = $urandom;
        cyc++;
        nreq++;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    check("resp_seen", {31'b0, seen}, 32'd1);
    check("resp_ins", IF_ins, exp_ins);
    check("mem_reads", nreq, exp_hit ? 32'd0 : 32'd4);
    check("latency", cyc, exp_hit ? 32'd1 : 32'(1 + 4 * lat));
    got_hit = (nreq == 0);
    got_ins = IF_ins;
    @(negedge clk);
    check("resp_pulse", {31'b0, IF_ins_sgn}, 32'd0);
    m_valid[idx] = 1'b1;
    m_tag[idx]   = tg;
  endtask

  initial begin
    logic        h;
    logic [31:0] ins;
    int          bad;

    tbl[0] = '{pc: 32'h0000_0000, ins: 32'h0000_0013, hit: 1'b0};
    tbl[1] = '{pc: 32'h0000_0008, ins: 32'h0020_0113, hit: 1'b1};
    tbl[2] = '{pc: 32'h0000_000C, ins: 32'h0030_0193, hit: 1'b1};
    tbl[3] = '{pc: 32'h0000_0004, ins: 32'h0010_0093, hit: 1'b1};
    tbl[4] = '{pc: 32'h0000_0400, ins: mem_rd(32'h400), hit: 1'b0};
    tbl[5] = '{pc: 32'h0000_040C, ins: mem_rd(32'h40C), hit: 1'b1};
    tbl[6] = '{pc: 32'h0000_0000, ins: 32'h0000_0013, hit: 1'b0};
    tbl[7] = '{pc: 32'h0000_0003, ins: 32'h0000_0013, hit: 1'b1};

    // Clock/reset
    rst = 1'b1; rdy = 1'b1; flush = 1'b0; IF_pc_sgn = 1'b0; IF_pc = '0;
    MC_done = 1'b0; MC_data = '0;
    model_clear();
    repeat (2) @(negedge clk);
    check("rst_ins_sgn", {31'b0, IF_ins_sgn}, 32'd0);
    check("rst_ins", IF_ins, 32'd0);
    check("rst_mc_req", {31'b0, MC_req}, 32'd0);
    check("rst_mc_addr", MC_addr, 32'd0);
    check("rst_state", {30'b0, dbg_state}, {30'b0, ST_IDLE});
    rst = 1'b0;
    @(negedge clk);

    // Directed table
    for (int i = 0; i < 8; i++) begin
      do_fetch(tbl[i].pc, 1, h, ins);
      check("tbl_hit", {31'b0, h}, {31'b0, tbl[i].hit});
      check("tbl_ins", ins, tbl[i].ins);
    end

    // Flush after the second beat, with a fetch offered in the flush cycle
    start_req(32'h0000_0800);
    beat(32'h0000_0800);
    beat(32'h0000_0804);
    flush = 1'b1; IF_pc_sgn = 1'b1; IF_pc = 32'h0000_0008;
    @(negedge clk);
    flush = 1'b0; IF_pc_sgn = 1'b0;
    check("flush_mc_req", {31'b0, MC_req}, 32'd0);
    check("flush_state", {30'b0, dbg_state}, {30'b0, ST_IDLE});
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      if (IF_ins_sgn || MC_req) bad++;
      @(negedge clk);
    end
    check("flush_quiet", bad, 32'd0);
    m_valid[0] = 1'b0;
    do_fetch(32'h0000_0000, 1, h, ins);
    check("flush_refill", {31'b0, h}, 32'd0);

    // Flush coinciding with the final beat
    start_req(32'h0000_0810);
    beat(32'h0000_0810);
    beat(32'h0000_0814);
    beat(32'h0000_0818);
    check("last_addr", MC_addr, 32'h0000_081C);
    MC_done = 1'b1; MC_data = mem_rd(32'h81C); flush = 1'b1;
    @(negedge clk);
    MC_done = 1'b0; flush = 1'b0;
    check("lastflush_req", {31'b0, MC_req}, 32'd0);
    check("lastflush_sgn", {31'b0, IF_ins_sgn}, 32'd0);
    m_valid[1] = 1'b0;
    do_fetch(32'h0000_0814, 1, h, ins);
    check("lastflush_miss", {31'b0, h}, 32'd0);

    // rdy low mid-fill: beats and a flush must be ignored
    start_req(32'h0000_1020);
    beat(32'h0000_1020);
    rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      MC_done = 1'b1; MC_data = $urandom; flush = (k == 1);
      @(negedge clk);
      check("frz_addr", MC_addr, 32'h0000_1024);
      check("frz_req", {31'b0, MC_req}, 32'd1);
      check("frz_sgn", {31'b0, IF_ins_sgn}, 32'd0);
    end
    MC_done = 1'b0; flush = 1'b0; rdy = 1'b1;
    beat(32'h0000_1024);
    beat(32'h0000_1028);
    beat(32'h0000_102C);
    check("frz_resp_sgn", {31'b0, IF_ins_sgn}, 32'd1);
    check("frz_resp_ins", IF_ins, mem_rd(32'h1020));
    @(negedge clk);
    m_valid[2] = 1'b1; m_tag[2] = 22'h4;

    // Reset mid-fill
    do_fetch(32'h0000_0008, 1, h, ins);
    check("pre_rst_hit", {31'b0, h}, 32'd1);
    start_req(32'h0000_1030);
    beat(32'h0000_1030);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_req", {31'b0, MC_req}, 32'd0);
    check("midrst_addr", MC_addr, 32'd0);
    check("midrst_ins", IF_ins, 32'd0);
    check("midrst_state", {30'b0, dbg_state}, {30'b0, ST_IDLE});
    model_clear();
    do_fetch(32'h0000_0008, 1, h, ins);
    check("post_rst_miss", {31'b0, h}, 32'd0);

    // Randomized fetches over a small footprint so hits, misses and evictions all occur
    for (int n = 0; n < 150; n++) begin
      logic [31:0] pc;
      pc = (32'($urandom_range(0, 2)) << 10) | (32'($urandom_range(0, 7)) << 4)
         | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      do_fetch(pc, int'($urandom_range(1, 3)), h, ins);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
